// File: rtl/keystream_arbiter_pkg.sv
// Shared types for the keystream byte arbiter.
package keystream_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    REKEY   = 3'd4
  } keystream_arb_state_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } keystream_ch_t;

  localparam int KEYSTREAM_QUEUE_MAX = 3;

  // Round-robin pick: alternate when both wait, otherwise take whoever is pending.
  function automatic keystream_ch_t pick_grant(input logic a_nz, input logic b_nz,
                                               input keystream_ch_t last);
    if (a_nz && b_nz) return (last == CH_A) ? CH_B : CH_A;
    else if (a_nz)    return CH_A;
    else              return CH_B;
  endfunction

endpackage

// File: rtl/keystream_req_counter.sv
// Per-channel saturating pending-request counter.
module keystream_req_counter
  import keystream_arbiter_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clear,
  output logic o_nonzero,
  output logic o_overflow
);

  logic [1:0] r_cnt;
  logic       w_full;

  assign w_full = (r_cnt == 2'(KEYSTREAM_QUEUE_MAX));

  // Count requests; a clear still admits a same-cycle request, inc+dec cancel out.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt <= 2'd0;
    end else if (i_clear) begin
      r_cnt <= {1'b0, i_inc};
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (!w_full)  r_cnt <= r_cnt + 2'd1;
        2'b01:   if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_nonzero  = (r_cnt != 2'd0);
  // A request is only lost when full and no slot frees up this cycle.
  assign o_overflow = i_inc & w_full & ~i_dec & ~i_clear;

endmodule

// File: rtl/keystream_arbiter.sv
// Shares one keystream byte generator between channels A and B with
// round-robin grant, per-request timeout and rekey sequencing.
module keystream_arbiter
  import keystream_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_a_pulse,
  input  logic       req_b_pulse,
  input  logic       rekey_pulse,
  output logic [7:0] byte_a_out,
  output logic       byte_a_pulse_out,
  output logic [7:0] byte_b_out,
  output logic       byte_b_pulse_out,
  output logic       gen_request_pulse_out,
  input  logic [7:0] gen_byte_in,
  input  logic       gen_byte_pulse_in,
  output logic       gen_reset_hash_out,
  output logic       busy_out,
  output logic       overflow_err_out,
  output logic       timeout_err_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  keystream_arb_state_t r_state, w_next;
  keystream_ch_t        r_grant, r_last;
  logic                 r_rekey;
  logic [TW-1:0]        r_tmo;
  logic [7:0]           r_byte_a, r_byte_b;
  logic                 r_ovf_err, r_tmo_err;

  logic w_a_nz, w_b_nz, w_a_ovf, w_b_ovf;
  logic w_dec_a, w_dec_b, w_clear;
  logic w_gen_hit, w_tmo_zero, w_grant_now;
  logic w_gen_req, w_reset_hash, w_strobe_a, w_strobe_b, w_busy;

  assign w_dec_a     = (r_state == ISSUE) && (r_grant == CH_A);
  assign w_dec_b     = (r_state == ISSUE) && (r_grant == CH_B);
  assign w_clear     = (r_state == REKEY);
  assign w_gen_hit   = (r_state == WAIT) && gen_byte_pulse_in;
  assign w_tmo_zero  = (r_tmo == '0);
  assign w_grant_now = (r_state == IDLE) && !r_rekey && (w_a_nz || w_b_nz);

  keystream_req_counter u_cnt_a (
    .clk       (clk),
    .nrst      (nrst),
    .i_inc     (req_a_pulse),
    .i_dec     (w_dec_a),
    .i_clear   (w_clear),
    .o_nonzero (w_a_nz),
    .o_overflow(w_a_ovf)
  );

  keystream_req_counter u_cnt_b (
    .clk       (clk),
    .nrst      (nrst),
    .i_inc     (req_b_pulse),
    .i_dec     (w_dec_b),
    .i_clear   (w_clear),
    .o_nonzero (w_b_nz),
    .o_overflow(w_b_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: rekey beats requests; a generator answer beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_rekey) w_next = REKEY;
               else if (w_a_nz || w_b_nz) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (gen_byte_pulse_in) w_next = DELIVER;
               else if (w_tmo_zero)   w_next = REKEY;
      DELIVER: w_next = IDLE;
      REKEY:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore output decodes from registered state and grant.
  always_comb begin
    w_gen_req    = (r_state == ISSUE);
    w_reset_hash = (r_state == REKEY);
    w_strobe_a   = (r_state == DELIVER) && (r_grant == CH_A);
    w_strobe_b   = (r_state == DELIVER) && (r_grant == CH_B);
    w_busy       = (r_state != IDLE);
  end

  // Grant, rekey latch, timeout counter, delivered bytes and sticky errors.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_grant   <= CH_A;
      r_last    <= CH_B;
      r_rekey   <= 1'b0;
      r_tmo     <= '0;
      r_byte_a  <= 8'd0;
      r_byte_b  <= 8'd0;
      r_ovf_err <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_grant_now) r_grant <= pick_grant(w_a_nz, w_b_nz, r_last);
      // A timed-out request does not move the pointer; the same channel stays favoured.
      if (r_state == DELIVER) r_last <= r_grant;
      // A new rekey during REKEY stays latched so the fresh key gets its own restart.
      if (rekey_pulse)             r_rekey <= 1'b1;
      else if (r_state == REKEY)   r_rekey <= 1'b0;
      if (r_state == ISSUE)                                        r_tmo <= TO_LOAD;
      else if (r_state == WAIT && !gen_byte_pulse_in && !w_tmo_zero) r_tmo <= r_tmo - 1'b1;
      // Latch on the WAIT->DELIVER edge so the byte and its strobe appear together.
      if (w_gen_hit && r_grant == CH_A) r_byte_a <= gen_byte_in;
      if (w_gen_hit && r_grant == CH_B) r_byte_b <= gen_byte_in;
      if (w_a_ovf || w_b_ovf) r_ovf_err <= 1'b1;
      if (r_state == WAIT && !gen_byte_pulse_in && w_tmo_zero) r_tmo_err <= 1'b1;
    end
  end

  assign byte_a_out            = r_byte_a;
  assign byte_b_out            = r_byte_b;
  assign byte_a_pulse_out      = w_strobe_a;
  assign byte_b_pulse_out      = w_strobe_b;
  assign gen_request_pulse_out = w_gen_req;
  assign gen_reset_hash_out    = w_reset_hash;
  assign busy_out              = w_busy;
  assign overflow_err_out      = r_ovf_err;
  assign timeout_err_out       = r_tmo_err;

endmodule

// File: tb/tb_keystream_arbiter.sv
// Scoreboard bench for keystream_arbiter with a latency-programmable generator model.
module tb_keystream_arbiter;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       req_a_pulse = 1'b0, req_b_pulse = 1'b0, rekey_pulse = 1'b0;
  logic [7:0] byte_a_out, byte_b_out, gen_byte_in;
  logic       byte_a_pulse_out, byte_b_pulse_out, gen_request_pulse_out;
  logic       gen_byte_pulse_in, gen_reset_hash_out, busy_out;
  logic       overflow_err_out, timeout_err_out;

  keystream_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .nrst                 (nrst),
    .req_a_pulse          (req_a_pulse),
    .req_b_pulse          (req_b_pulse),
    .rekey_pulse          (rekey_pulse),
    .byte_a_out           (byte_a_out),
    .byte_a_pulse_out     (byte_a_pulse_out),
    .byte_b_out           (byte_b_out),
    .byte_b_pulse_out     (byte_b_pulse_out),
    .gen_request_pulse_out(gen_request_pulse_out),
    .gen_byte_in          (gen_byte_in),
    .gen_byte_pulse_in    (gen_byte_pulse_in),
    .gen_reset_hash_out   (gen_reset_hash_out),
    .busy_out             (busy_out),
    .overflow_err_out     (overflow_err_out),
    .timeout_err_out      (timeout_err_out)
  );

  always #5 clk = ~clk;

  typedef struct { bit ch; logic [7:0] b; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] gen_q[$];

  int n_tot = 0, n_bad = 0;
  int cyc = 0;
  int gen_lat = 0;
  int n_req = 0, n_rst = 0, n_a = 0, n_b = 0;
  int req_cyc = 0, rst_cyc = 0, a_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: answers gen_lat cycles after an observed request (0 = never).
  initial begin
    int cd;
    cd = 0;
    gen_byte_pulse_in = 1'b0;
    gen_byte_in = 8'h00;
    forever begin
      @(posedge clk); #1;
      gen_byte_pulse_in = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          gen_byte_pulse_in = 1'b1;
          gen_byte_in = (gen_q.size() != 0) ? gen_q.pop_front() : 8'h00;
        end
      end
      if (gen_request_pulse_out && gen_lat > 0) cd = gen_lat;
    end
  end

  // Output monitor: pops the scoreboard on every delivery strobe.
  always @(negedge clk) begin
    exp_t e;
    if (gen_request_pulse_out) begin n_req++; req_cyc = cyc; end
    if (gen_reset_hash_out)    begin n_rst++; rst_cyc = cyc; end
    if (byte_a_pulse_out || byte_b_pulse_out) begin
      if (byte_a_pulse_out) begin n_a++; a_cyc = cyc; end
      if (byte_b_pulse_out) n_b++;
      if (exp_q.size() == 0) chk("deliv_expected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("deliv_chan", {31'd0, byte_b_pulse_out}, {31'd0, e.ch});
        chk("deliv_byte", 32'(byte_b_pulse_out ? byte_b_out : byte_a_out), 32'(e.b));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input bit ch, input logic [7:0] b);
    exp_t e;
    e.ch = ch; e.b = b;
    exp_q.push_back(e);
    gen_q.push_back(b);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick(2);
    chk("rst_bytes",   {16'd0, byte_a_out, byte_b_out}, 32'd0);
    chk("rst_strobes", {28'd0, byte_a_pulse_out, byte_b_pulse_out,
                        gen_request_pulse_out, gen_reset_hash_out}, 32'd0);
    chk("rst_status",  {29'd0, busy_out, overflow_err_out, timeout_err_out}, 32'd0);
    exp_q.delete();
    gen_q.delete();
    nrst = 1'b1;
    tick(2);
  endtask

  initial begin
    int t0, b_req, b_rst, b_a, b_b;

    // Single request, L=4.
    do_reset();
    gen_lat = 4;
    push(1'b0, 8'hA5);
    b_req = n_req; b_b = n_b;
    req_a_pulse = 1'b1; t0 = cyc; tick(1); req_a_pulse = 1'b0;
    tick(12);
    chk("single_req_cyc",  32'(req_cyc - t0), 32'd2);
    chk("single_strb_cyc", 32'(a_cyc - t0), 32'd7);
    chk("single_nreq",     32'(n_req - b_req), 32'd1);
    chk("single_b_quiet",  32'(n_b - b_b), 32'd0);
    chk("single_byte_hold", 32'(byte_a_out), 32'hA5);
    chk("single_drain",    32'(exp_q.size()), 32'd0);

    // Fairness: A and B together, twice.
    do_reset();
    gen_lat = 2;
    push(1'b0, 8'h11); push(1'b1, 8'h22); push(1'b0, 8'h33); push(1'b1, 8'h44);
    b_req = n_req;
    req_a_pulse = 1'b1; req_b_pulse = 1'b1; tick(2);
    req_a_pulse = 1'b0; req_b_pulse = 1'b0;
    tick(30);
    chk("fair_nreq",  32'(n_req - b_req), 32'd4);
    chk("fair_drain", 32'(exp_q.size()), 32'd0);
    chk("fair_b_hold", 32'(byte_b_out), 32'h44);

    // Overflow: one in flight, four more while WAIT stalls.
    do_reset();
    gen_lat = 7;
    for (int i = 0; i < 4; i++) push(1'b0, 8'(8'h60 + i));
    b_a = n_a;
    req_a_pulse = 1'b1; tick(1); req_a_pulse = 1'b0;
    tick(2);
    req_a_pulse = 1'b1; tick(3);
    chk("ovf_not_yet", {31'd0, overflow_err_out}, 32'd0);
    tick(1); req_a_pulse = 1'b0;
    tick(1);
    chk("ovf_set", {31'd0, overflow_err_out}, 32'd1);
    tick(55);
    chk("ovf_deliv", 32'(n_a - b_a), 32'd4);
    chk("ovf_drain", 32'(exp_q.size()), 32'd0);
    chk("ovf_no_tmo", {31'd0, timeout_err_out}, 32'd0);

    // Timeout: generator silent, TIMEOUT_CYCLES=8.
    do_reset();
    gen_lat = 0;
    b_rst = n_rst; b_a = n_a;
    req_a_pulse = 1'b1; t0 = cyc; tick(1); req_a_pulse = 1'b0;
    tick(9);
    chk("tmo_not_yet", {31'd0, timeout_err_out}, 32'd0);
    tick(6);
    chk("tmo_err",     {31'd0, timeout_err_out}, 32'd1);
    chk("tmo_wait_len", 32'(rst_cyc - req_cyc - 1), 32'd8);
    chk("tmo_rst_at",  32'(rst_cyc - t0), 32'd11);
    chk("tmo_nrst",    32'(n_rst - b_rst), 32'd1);
    chk("tmo_no_a",    32'(n_a - b_a), 32'd0);
    chk("tmo_idle",    {31'd0, busy_out}, 32'd0);

    // Rekey during WAIT with B=2 pending.
    do_reset();
    gen_lat = 5;
    push(1'b0, 8'h5A);
    b_req = n_req; b_rst = n_rst; b_b = n_b;
    req_a_pulse = 1'b1; t0 = cyc; tick(1); req_a_pulse = 1'b0;
    tick(2);
    req_b_pulse = 1'b1; tick(2); req_b_pulse = 1'b0;
    rekey_pulse = 1'b1; tick(1); rekey_pulse = 1'b0;
    tick(25);
    chk("rk_nreq",   32'(n_req - b_req), 32'd1);
    chk("rk_nrst",   32'(n_rst - b_rst), 32'd1);
    chk("rk_rst_at", 32'(rst_cyc - t0), 32'd10);
    chk("rk_no_b",   32'(n_b - b_b), 32'd0);
    chk("rk_drain",  32'(exp_q.size()), 32'd0);
    chk("rk_idle",   {31'd0, busy_out}, 32'd0);

    // Rekey beats a simultaneous request; a request in the REKEY cycle survives.
    do_reset();
    gen_lat = 2;
    push(1'b0, 8'h77);
    b_req = n_req; b_rst = n_rst;
    rekey_pulse = 1'b1; req_a_pulse = 1'b1; t0 = cyc; tick(1);
    rekey_pulse = 1'b0; req_a_pulse = 1'b0;
    tick(1);
    req_a_pulse = 1'b1; tick(1); req_a_pulse = 1'b0;
    tick(15);
    chk("pri_rst_at", 32'(rst_cyc - t0), 32'd2);
    chk("pri_req_at", 32'(req_cyc - t0), 32'd4);
    chk("pri_nreq",   32'(n_req - b_req), 32'd1);
    chk("pri_nrst",   32'(n_rst - b_rst), 32'd1);
    chk("pri_drain",  32'(exp_q.size()), 32'd0);

    // Reset during WAIT, then the late generator answer arrives as a stray.
    do_reset();
    gen_lat = 4;
    gen_q.push_back(8'hC3);
    b_req = n_req; b_a = n_a;
    req_a_pulse = 1'b1; tick(1); req_a_pulse = 1'b0;
    tick(3);
    nrst = 1'b0; tick(1);
    chk("mid_rst_outs", {byte_a_out, byte_b_out, 8'd0, byte_a_pulse_out, byte_b_pulse_out,
                         gen_request_pulse_out, gen_reset_hash_out, busy_out,
                         overflow_err_out, timeout_err_out, 1'b0}, 32'd0);
    nrst = 1'b1;
    tick(12);
    chk("mid_stray_a",    32'(n_a - b_a), 32'd0);
    chk("mid_stray_byte", 32'(byte_a_out), 32'd0);
    chk("mid_stray_nreq", 32'(n_req - b_req), 32'd1);
    chk("mid_stray_idle", {31'd0, busy_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
